// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and its width.
package reset_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// Single-bit synchroniser: clears asynchronously, sets only through STAGES clock edges.
module reset_sync_chain #(
    parameter int STAGES = 3
) (
    input  logic clock_i,
    input  logic asynch_reset_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift d_i towards the output; asynchronous clear forces the whole chain low.
    always_ff @(posedge clock_i or negedge asynch_reset_n_i) begin
        if (!asynch_reset_n_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Top-level reset sequencer: synchronises reset and PLL lock, holds all
// outputs for MIN_ASSERT cycles, then releases them one by one.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int NUM_OUTPUTS = 4,
    parameter int MIN_ASSERT  = 8,
    parameter int STAGE_DELAY = 16
) (
    input  logic                   clock,
    input  logic                   asynch_reset_n,
    input  logic                   pll_locked,
    input  logic                   sw_reset_req,
    output logic [NUM_OUTPUTS-1:0] reset_n,
    output logic                   sequence_done,
    output logic                   lock_lost,
    output logic [STATE_W-1:0]     seq_state
);

    localparam int MAX_CNT = (MIN_ASSERT > STAGE_DELAY) ? MIN_ASSERT : STAGE_DELAY;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = $clog2(NUM_OUTPUTS + 1);

    localparam logic [CNT_W-1:0] MIN_LOAD   = CNT_W'(MIN_ASSERT);
    localparam logic [CNT_W-1:0] STAGE_LOAD = CNT_W'(STAGE_DELAY);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_OUTPUTS - 1);

    logic rst_sync_n;
    logic pll_sync;
    logic good;

    seq_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_OUTPUTS-1:0] rstn_q, rstn_d;
    logic                   lock_lost_q, lock_lost_d;

    reset_sync_chain #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .clock_i          (clock),
        .asynch_reset_n_i (asynch_reset_n),
        .d_i              (1'b1),
        .q_o              (rst_sync_n)
    );

    reset_sync_chain #(.STAGES(SYNC_STAGES)) u_pll_sync (
        .clock_i          (clock),
        .asynch_reset_n_i (asynch_reset_n),
        .d_i              (pll_locked),
        .q_o              (pll_sync)
    );

    assign good = rst_sync_n & pll_sync & ~sw_reset_req;

    // Next-state logic: counting in HOLD/RELEASE, abort to HOLD whenever good drops.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rstn_d      = rstn_q;
        lock_lost_d = lock_lost_q;

        // Only a lock drop seen after a completed sequence is recorded.
        if ((state_q == RUN) && !pll_sync) begin
            lock_lost_d = 1'b1;
        end

        case (state_q)
            HOLD: begin
                rstn_d = '0;
                idx_d  = '0;
                if (!good) begin
                    cnt_d = MIN_LOAD;
                end else if (cnt_q <= CNT_ONE) begin
                    // Counter reaches zero on this edge: release the first output.
                    rstn_d[0] = 1'b1;
                    idx_d     = IDX_ONE;
                    cnt_d     = STAGE_LOAD;
                    state_d   = (NUM_OUTPUTS == 1) ? RUN : RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RELEASE: begin
                if (!good) begin
                    state_d = HOLD;
                    rstn_d  = '0;
                    cnt_d   = MIN_LOAD;
                    idx_d   = '0;
                end else if (cnt_q <= CNT_ONE) begin
                    for (int k = 0; k < NUM_OUTPUTS; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            rstn_d[k] = 1'b1;
                        end
                    end
                    idx_d = idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = STAGE_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RUN: begin
                rstn_d = '1;
                if (!good) begin
                    state_d = HOLD;
                    rstn_d  = '0;
                    cnt_d   = MIN_LOAD;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = HOLD;
                rstn_d  = '0;
                cnt_d   = MIN_LOAD;
                idx_d   = '0;
            end
        endcase
    end

    // State registers; asynchronous reset drops every output immediately.
    always_ff @(posedge clock or negedge asynch_reset_n) begin
        if (!asynch_reset_n) begin
            state_q     <= HOLD;
            cnt_q       <= MIN_LOAD;
            idx_q       <= '0;
            rstn_q      <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rstn_q      <= rstn_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign reset_n       = rstn_q;
    assign sequence_done = (state_q == RUN);
    assign lock_lost     = lock_lost_q;
    assign seq_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a minimal-parameter instance.
module tb_reset_sequencer;

    logic       clock;
    logic       asynch_reset_n;
    logic       pll_locked;
    logic       sw_reset_req;

    logic [3:0] reset_n;
    logic       sequence_done;
    logic       lock_lost;
    logic [1:0] seq_state;

    logic [0:0] s_reset_n;
    logic       s_sequence_done;
    logic       s_lock_lost;
    logic [1:0] s_seq_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic s_saw_release = 1'b0;

    reset_sequencer dut (
        .clock          (clock),
        .asynch_reset_n (asynch_reset_n),
        .pll_locked     (pll_locked),
        .sw_reset_req   (sw_reset_req),
        .reset_n        (reset_n),
        .sequence_done  (sequence_done),
        .lock_lost      (lock_lost),
        .seq_state      (seq_state)
    );

    reset_sequencer #(
        .SYNC_STAGES (2),
        .NUM_OUTPUTS (1),
        .MIN_ASSERT  (1),
        .STAGE_DELAY (1)
    ) dut_small (
        .clock          (clock),
        .asynch_reset_n (asynch_reset_n),
        .pll_locked     (pll_locked),
        .sw_reset_req   (sw_reset_req),
        .reset_n        (s_reset_n),
        .sequence_done  (s_sequence_done),
        .lock_lost      (s_lock_lost),
        .seq_state      (s_seq_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (s_seq_state == 2'd1) s_saw_release <= 1'b1;
    end

    // Advance to 1 time unit after rising edge number n.
    task automatic at_edge(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
        $display("check %s edge=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    initial begin
        asynch_reset_n = 1'b0;
        pll_locked     = 1'b1;
        sw_reset_req   = 1'b0;
        #1;
        chk("por_reset_n", 8'(reset_n), 8'h0);
        chk("por_done", 8'(sequence_done), 8'h0);
        chk("por_lock_lost", 8'(lock_lost), 8'h0);
        chk("por_state", 8'(seq_state), 8'h0);
        #1;
        asynch_reset_n = 1'b1;

        // Minimal-parameter instance: release at edge 3, straight to RUN.
        at_edge(2);
        chk("small_e2_rstn", 8'(s_reset_n), 8'h0);
        chk("small_e2_state", 8'(s_seq_state), 8'h0);
        at_edge(3);
        chk("small_e3_rstn", 8'(s_reset_n), 8'h1);
        chk("small_e3_done", 8'(s_sequence_done), 8'h1);
        chk("small_e3_state", 8'(s_seq_state), 8'h2);

        // Power-up release: 11, 27, 43, 59.
        at_edge(10); chk("pu_e10", 8'(reset_n), 8'h0);
        at_edge(11); chk("pu_e11", 8'(reset_n), 8'h1);
                     chk("pu_e11_state", 8'(seq_state), 8'h1);
        at_edge(26); chk("pu_e26", 8'(reset_n), 8'h1);
        at_edge(27); chk("pu_e27", 8'(reset_n), 8'h3);
        at_edge(42); chk("pu_e42", 8'(reset_n), 8'h3);
        at_edge(43); chk("pu_e43", 8'(reset_n), 8'h7);
        at_edge(58); chk("pu_e58", 8'(reset_n), 8'h7);
                     chk("pu_e58_done", 8'(sequence_done), 8'h0);
        at_edge(59); chk("pu_e59", 8'(reset_n), 8'hf);
                     chk("pu_e59_done", 8'(sequence_done), 8'h1);
                     chk("pu_e59_state", 8'(seq_state), 8'h2);

        // One-cycle soft reset request in RUN.
        at_edge(100); sw_reset_req = 1'b1;
        at_edge(101); sw_reset_req = 1'b0;
        chk("sw_e101", 8'(reset_n), 8'h0);
        chk("sw_e101_done", 8'(sequence_done), 8'h0);
        chk("sw_e101_state", 8'(seq_state), 8'h0);
        at_edge(108); chk("sw_e108", 8'(reset_n), 8'h0);
        at_edge(109); chk("sw_e109", 8'(reset_n), 8'h1);
                      chk("sw_lock_lost", 8'(lock_lost), 8'h0);
        at_edge(157); chk("sw_e157", 8'(reset_n), 8'hf);

        // PLL lock loss in RUN, then relock.
        at_edge(200); pll_locked = 1'b0;
        at_edge(203); chk("pll_e203", 8'(reset_n), 8'hf);
                      chk("pll_e203_ll", 8'(lock_lost), 8'h0);
        at_edge(204); chk("pll_e204", 8'(reset_n), 8'h0);
                      chk("pll_e204_ll", 8'(lock_lost), 8'h1);
                      chk("pll_e204_done", 8'(sequence_done), 8'h0);
        at_edge(250); pll_locked = 1'b1;
        at_edge(260); chk("relock_e260", 8'(reset_n), 8'h0);
        at_edge(261); chk("relock_e261", 8'(reset_n), 8'h1);
        at_edge(277); chk("relock_e277", 8'(reset_n), 8'h3);
                      chk("relock_ll", 8'(lock_lost), 8'h1);

        // Asynchronous reset mid-RELEASE: immediate clear, full restart.
        at_edge(280); asynch_reset_n = 1'b0;
        #1;
        chk("ar_rstn", 8'(reset_n), 8'h0);
        chk("ar_ll", 8'(lock_lost), 8'h0);
        chk("ar_state", 8'(seq_state), 8'h0);
        at_edge(282); asynch_reset_n = 1'b1;
        at_edge(292); chk("ar_e292", 8'(reset_n), 8'h0);
        at_edge(293); chk("ar_e293", 8'(reset_n), 8'h1);
        at_edge(309); chk("ar_e309", 8'(reset_n), 8'h3);
        at_edge(325); chk("ar_e325", 8'(reset_n), 8'h7);
        at_edge(340); chk("ar_e340_done", 8'(sequence_done), 8'h0);
        at_edge(341); chk("ar_e341", 8'(reset_n), 8'hf);
                      chk("ar_e341_done", 8'(sequence_done), 8'h1);

        // Power-up with PLL unlocked until relative edge 40: release at +51.
        at_edge(350); pll_locked = 1'b0; asynch_reset_n = 1'b0;
        at_edge(351); asynch_reset_n = 1'b1;
        at_edge(391); pll_locked = 1'b1;
        at_edge(401); chk("pl_e401", 8'(reset_n), 8'h0);
                      chk("pl_e401_state", 8'(seq_state), 8'h0);
        at_edge(402); chk("pl_e402", 8'(reset_n), 8'h1);
        at_edge(418); chk("pl_e418", 8'(reset_n), 8'h3);
        at_edge(450); chk("pl_e450", 8'(reset_n), 8'hf);
                      chk("pl_e450_ll", 8'(lock_lost), 8'h0);

        chk("small_no_release", 8'(s_saw_release), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
